// File: rtl/ks_adder_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ks_pkg : prefix-tree sizing helpers for the pipelined Kogge-Stone adder
// Revision 1.0
// ----------------------------------------------------------------------------
package ks_pkg;

    // ceil(log2(width)) for width >= 2
    function automatic int ks_levels(input int width);
        int lv;
        lv = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < width) begin
                lv = i + 1;
            end
        end
        return lv;
    endfunction

    function automatic int ks_stages(input int levels, input int per);
        return (levels + per - 1) / per;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ks_adder_pipe_level.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ks_prefix_level : one combinational Kogge-Stone row of black cells at DIST
// Revision 1.0
// ----------------------------------------------------------------------------
module ks_prefix_level #(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] g_i,
    output logic [WIDTH-1:0] p_o,
    output logic [WIDTH-1:0] g_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_black
            assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-DIST]);
            assign p_o[i] = p_i[i] & p_i[i-DIST];
        end else begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ks_adder_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ks_adder_pipe : pipelined Kogge-Stone adder/subtractor with valid/ready flow
// Revision 1.0
// ----------------------------------------------------------------------------
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int STAGE_LEVELS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int L    = ks_levels(WIDTH);
    localparam int NSTG = ks_stages(L, STAGE_LEVELS);
    localparam int NMID = (NSTG > 1) ? NSTG - 1 : 1;

    logic [WIDTH-1:0] w_bx, w_p0, w_g0;
    logic             w_c0;

    // Carry-in is folded into the bit-0 generate so the tree needs no extra row.
    always_comb begin
        w_bx    = in_sub ? ~in_b : in_b;
        w_c0    = in_sub | in_cin;
        w_p0    = in_a ^ w_bx;
        w_g0    = in_a & w_bx;
        w_g0[0] = w_g0[0] | (w_p0[0] & w_c0);
    end

    logic [WIDTH-1:0] mid_p_q  [NMID];
    logic [WIDTH-1:0] mid_g_q  [NMID];
    logic [WIDTH-1:0] mid_po_q [NMID];
    logic             mid_c0_q [NMID];
    logic             mid_v_q  [NMID];

    logic [WIDTH-1:0] lvl_pi [L];
    logic [WIDTH-1:0] lvl_gi [L];
    logic [WIDTH-1:0] lvl_po [L];
    logic [WIDTH-1:0] lvl_go [L];

    logic [WIDTH-1:0] stg_p  [NSTG];
    logic [WIDTH-1:0] stg_g  [NSTG];
    logic [WIDTH-1:0] stg_po [NSTG];
    logic             stg_c0 [NSTG];
    logic             stg_v  [NSTG];

    logic [NSTG-1:0]  w_adv;
    logic             w_chain;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int STG = k / STAGE_LEVELS;
        if (k == 0) begin : g_first
            assign lvl_pi[k] = w_p0;
            assign lvl_gi[k] = w_g0;
        end else if ((k % STAGE_LEVELS) == 0) begin : g_reg
            assign lvl_pi[k] = mid_p_q[STG-1];
            assign lvl_gi[k] = mid_g_q[STG-1];
        end else begin : g_chain
            assign lvl_pi[k] = lvl_po[k-1];
            assign lvl_gi[k] = lvl_go[k-1];
        end
        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .p_i (lvl_pi[k]),
            .g_i (lvl_gi[k]),
            .p_o (lvl_po[k]),
            .g_o (lvl_go[k])
        );
    end

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        localparam int LAST = (((s + 1) * STAGE_LEVELS < L) ? (s + 1) * STAGE_LEVELS : L) - 1;
        assign stg_p[s] = lvl_po[LAST];
        assign stg_g[s] = lvl_go[LAST];
        if (s == 0) begin : g_head
            assign stg_po[s] = w_p0;
            assign stg_c0[s] = w_c0;
            assign stg_v[s]  = in_valid;
        end else begin : g_tail
            assign stg_po[s] = mid_po_q[s-1];
            assign stg_c0[s] = mid_c0_q[s-1];
            assign stg_v[s]  = mid_v_q[s-1];
        end
    end

    logic             out_v_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;

    // Ready chain: a stage may load when empty or when its successor is moving.
    always_comb begin
        w_adv         = '0;
        w_chain       = out_ready | ~out_v_q;
        w_adv[NSTG-1] = w_chain;
        for (int s = NSTG - 2; s >= 0; s--) begin
            w_chain  = w_chain | ~mid_v_q[s];
            w_adv[s] = w_chain;
        end
    end

    assign in_ready = w_adv[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NMID; s++) begin
                mid_v_q[s] <= 1'b0;
            end
        end else begin
            for (int s = 0; s < NSTG - 1; s++) begin
                if (w_adv[s]) begin
                    mid_v_q[s]  <= stg_v[s];
                    mid_p_q[s]  <= stg_p[s];
                    mid_g_q[s]  <= stg_g[s];
                    mid_po_q[s] <= stg_po[s];
                    mid_c0_q[s] <= stg_c0[s];
                end
            end
        end
    end

    always_comb begin
        sum_d  = stg_po[NSTG-1] ^ {stg_g[NSTG-1][WIDTH-2:0], stg_c0[NSTG-1]};
        cout_d = stg_g[NSTG-1][WIDTH-1];
        ovf_d  = stg_g[NSTG-1][WIDTH-1] ^ stg_g[NSTG-1][WIDTH-2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (w_adv[NSTG-1]) begin
            out_v_q <= stg_v[NSTG-1];
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = out_v_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ks_adder_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ks_adder_pipe : directed and randomized checks of ks_adder_pipe variants
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_ks_adder_pipe;

    localparam int NI    = 4;
    localparam int WID [NI] = '{5, 8, 16, 32};
    localparam int LAT [NI] = '{1, 3, 2, 3};
    localparam int NRAND = 2500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NI-1:0]   vld, ordy, cin, sub;
    logic [NI-1:0]   irdy, ovld, ocout, oovf;
    logic [31:0]     a [NI];
    logic [31:0]     b [NI];
    logic [31:0]     osum [NI];
    logic [4:0]      sum0;
    logic [7:0]      sum1;
    logic [15:0]     sum2;
    logic [31:0]     sum3;

    int errors = 0;
    int checks = 0;

    assign osum[0] = {27'd0, sum0};
    assign osum[1] = {24'd0, sum1};
    assign osum[2] = {16'd0, sum2};
    assign osum[3] = sum3;

    ks_adder_pipe #(.WIDTH(5), .STAGE_LEVELS(4)) u_w5 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(irdy[0]),
        .in_a(a[0][4:0]), .in_b(b[0][4:0]), .in_cin(cin[0]), .in_sub(sub[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .out_sum(sum0),
        .out_cout(ocout[0]), .out_ovf(oovf[0]));

    ks_adder_pipe #(.WIDTH(8), .STAGE_LEVELS(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(irdy[1]),
        .in_a(a[1][7:0]), .in_b(b[1][7:0]), .in_cin(cin[1]), .in_sub(sub[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .out_sum(sum1),
        .out_cout(ocout[1]), .out_ovf(oovf[1]));

    ks_adder_pipe #(.WIDTH(16), .STAGE_LEVELS(2)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(irdy[2]),
        .in_a(a[2][15:0]), .in_b(b[2][15:0]), .in_cin(cin[2]), .in_sub(sub[2]),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .out_sum(sum2),
        .out_cout(ocout[2]), .out_ovf(oovf[2]));

    ks_adder_pipe #(.WIDTH(32), .STAGE_LEVELS(2)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[3]), .in_ready(irdy[3]),
        .in_a(a[3]), .in_b(b[3]), .in_cin(cin[3]), .in_sub(sub[3]),
        .out_valid(ovld[3]), .out_ready(ordy[3]), .out_sum(sum3),
        .out_cout(ocout[3]), .out_ovf(oovf[3]));

    // Arithmetic reference: unsigned sum/borrow and signed range check.
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] av,
                                              input logic [31:0] bv, input logic c,
                                              input logic s);
        longint m, ua, ub, sa, sb, t;
        logic   co, ov;
        m  = longint'(1) << w;
        ua = longint'(av) & (m - 1);
        ub = longint'(bv) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            co = (ua >= ub);
            t  = sa - sb;
        end else begin
            co = ((ua + ub + longint'(c)) >= m);
            t  = sa + sb + longint'(c);
        end
        ov = (t > (m / 2 - 1)) || (t < -(m / 2));
        return {ov, co, 32'(t & (m - 1))};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        vld[2] = 1'b1;
        a[2]   = 32'h1234;
        b[2]   = 32'h4321;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++;
            if (ovld[2] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, ovld[2]);
            end
            checks++;
            if (irdy[2] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready cyc%0d: got %b want 1", c, irdy[2]);
            end
        end
        checks++;
        if ({oovf[2], ocout[2], osum[2]} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ovf=%b cout=%b sum=%h want all 0",
                     oovf[2], ocout[2], osum[2]);
        end
        rst_n = 1'b1;
        vld   = '0;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++;
            if (ovld !== '0) begin
                errors++;
                $display("FAIL post_reset_idle cyc%0d: got out_valid=%b want 0000", c, ovld);
            end
        end
    endtask

    task automatic test_directed;
        int          ti [7] = '{2, 2, 2, 1, 0, 3, 3};
        logic [31:0] ta [7] = '{32'hFFFF, 32'h7FFF, 32'h0005, 32'hAA, 32'h0F,
                                32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] tb [7] = '{32'h0001, 32'h0001, 32'h0007, 32'h55, 32'h01,
                                32'hFFFF_FFFF, 32'h0000_0001};
        logic        tc [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        ts [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] es [7] = '{32'h0000, 32'h8000, 32'hFFFE, 32'h00, 32'h10,
                                32'h0, 32'h7FFF_FFFF};
        logic        ec [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        eo [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int r = 0; r < 7; r++) begin
            int i;
            int lat;
            i       = ti[r];
            a[i]    = ta[r];
            b[i]    = tb[r];
            cin[i]  = tc[r];
            sub[i]  = ts[r];
            vld[i]  = 1'b1;
            ordy[i] = 1'b1;
            #1;
            checks++;
            if (irdy[i] !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_in_ready: got %b want 1", r, irdy[i]);
            end
            tick;
            vld[i] = 1'b0;
            lat    = 1;
            while (ovld[i] !== 1'b1 && lat < 20) begin
                tick;
                lat++;
            end
            checks++;
            if (lat != LAT[i]) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d want %0d", r, lat, LAT[i]);
            end
            checks++;
            if ({oovf[i], ocout[i], osum[i]} !== {eo[r], ec[r], es[r]}) begin
                errors++;
                $display("FAIL dir%0d_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         r, osum[i], ocout[i], oovf[i], es[r], ec[r], eo[r]);
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] q[$];
        logic [31:0] hsum, ex;
        logic        held, exp_rdy, acc, pop;
        int          sent, got, occ, cyc;
        sent = 0; got = 0; occ = 0; cyc = 0; held = 1'b0; hsum = '0;
        cin[2] = 1'b0;
        sub[2] = 1'b0;
        while ((sent < 5 || got < 5) && cyc < 100) begin
            if (sent < 5) begin
                vld[2] = 1'b1;
                a[2]   = 32'(sent + 1);
                b[2]   = 32'(sent + 1);
            end else begin
                vld[2] = 1'b0;
            end
            ordy[2] = (cyc >= 4);
            #1;
            if (held) begin
                checks++;
                if (ovld[2] !== 1'b1 || osum[2] !== hsum) begin
                    errors++;
                    $display("FAIL bp_stall_stable cyc%0d: got valid=%b sum=%h want valid=1 sum=%h",
                             cyc, ovld[2], osum[2], hsum);
                end
            end
            exp_rdy = (occ < LAT[2]) || ordy[2];
            checks++;
            if (irdy[2] !== exp_rdy) begin
                errors++;
                $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, irdy[2], exp_rdy);
            end
            pop = ovld[2] && ordy[2];
            if (pop) begin
                checks++;
                ex = (q.size() != 0) ? q.pop_front() : 32'hDEAD;
                if (osum[2] !== ex) begin
                    errors++;
                    $display("FAIL bp_order beat%0d: got %h want %h", got, osum[2], ex);
                end
                got++;
            end
            held = ovld[2] && !ordy[2];
            hsum = osum[2];
            acc  = vld[2] && irdy[2];
            if (acc) begin
                q.push_back(32'((sent + 1) * 2));
                sent++;
            end
            occ = occ + int'(acc) - int'(pop);
            tick;
            cyc++;
        end
        checks++;
        if (got != 5 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_delivered: got %0d beats left %0d want 5 left 0", got, q.size());
        end
        vld[2]  = 1'b0;
        ordy[2] = 1'b1;
        tick;
    endtask

    task automatic test_reset_midflight;
        ordy[1] = 1'b1;
        cin[1]  = 1'b0;
        sub[1]  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vld[1] = 1'b1;
            a[1]   = 32'(k + 3);
            b[1]   = 32'(k + 3);
            #1;
            checks++;
            if (irdy[1] !== 1'b1) begin
                errors++;
                $display("FAIL midrst_accept%0d: got in_ready=%b want 1", k, irdy[1]);
            end
            tick;
        end
        vld[1] = 1'b0;
        rst_n  = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (ovld[1] !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_output cyc%0d: got out_valid=%b want 0", c, ovld[1]);
            end
            tick;
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < NI; i++) begin
            logic [33:0] q[$];
            logic [33:0] ex;
            logic [31:0] mask;
            logic        exp_rdy, acc, pop;
            int          sent, got, occ, cyc;
            mask = (WID[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WID[i]) - 32'd1);
            sent = 0; got = 0; occ = 0; cyc = 0;
            while ((sent < NRAND || got < NRAND) && cyc < 40000) begin
                if (sent < NRAND && $urandom_range(0, 3) != 0) begin
                    vld[i] = 1'b1;
                    a[i]   = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom) & mask;
                    b[i]   = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom) & mask;
                    cin[i] = 1'($urandom_range(0, 1));
                    sub[i] = 1'($urandom_range(0, 1));
                end else begin
                    vld[i] = 1'b0;
                end
                ordy[i] = ($urandom_range(0, 9) < 7);
                #1;
                exp_rdy = (occ < LAT[i]) || ordy[i];
                checks++;
                if (irdy[i] !== exp_rdy) begin
                    errors++;
                    $display("FAIL rnd_w%0d_in_ready cyc%0d: got %b want %b", WID[i], cyc, irdy[i], exp_rdy);
                end
                pop = ovld[i] && ordy[i];
                if (pop) begin
                    checks++;
                    ex = (q.size() != 0) ? q.pop_front() : 34'h3_DEAD_BEEF;
                    if ({oovf[i], ocout[i], osum[i]} !== ex) begin
                        errors++;
                        $display("FAIL rnd_w%0d_result beat%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                 WID[i], got, oovf[i], ocout[i], osum[i], ex[33], ex[32], ex[31:0]);
                    end
                    got++;
                end
                acc = vld[i] && irdy[i];
                if (acc) begin
                    q.push_back(ref_model(WID[i], a[i], b[i], cin[i], sub[i]));
                    sent++;
                end
                occ = occ + int'(acc) - int'(pop);
                tick;
                cyc++;
            end
            checks++;
            if (got != NRAND || q.size() != 0) begin
                errors++;
                $display("FAIL rnd_w%0d_delivered: got %0d left %0d want %0d left 0",
                         WID[i], got, q.size(), NRAND);
            end
            vld[i]  = 1'b0;
            ordy[i] = 1'b1;
            tick;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = '0;
        ordy  = '1;
        cin   = '0;
        sub   = '0;
        for (int i = 0; i < NI; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_midflight;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ks_adder_pipe.md
Name: ks_adder_pipe

Overview:
Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor and the WIDTH-generic successor of the 8-bit prefix adder.
- Full prefix tree of ceil(log2(WIDTH)) levels, with pipeline registers every STAGE_LEVELS levels.
- Carry-in folded into bit 0 generate.
- Valid/ready handshake on both sides with full-throughput backpressure.
- Sits in the datapath as a drop-in arithmetic unit for wide operands.

Parameters:
WIDTH, 16, operand/sum width in bits (>=2)
STAGE_LEVELS, 2, prefix levels per pipeline stage (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in (ignored when in_sub=1)
in_sub  in  1  0: A+B+cin, 1: A-B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_sum  out  WIDTH  result
out_cout  out  1  carry-out (sub: 1 = no borrow)
out_ovf  out  1  signed overflow

Behaviour:
Derived constants:
- L = ceil(log2(WIDTH)).
- NSTG = ceil(L/STAGE_LEVELS), which is also the latency.

Arithmetic:
- B' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
- Per bit: P = A^B', G = A&B'. Bit 0 uses G0' = G0 | (P0 & c0).
- Prefix level k (distance d = 2^k), bit i >= d: G = Gi | (Pi & G[i-d]), P = Pi & P[i-d]. Bits i < d pass through unchanged.
- sum[0] = P0^c0; sum[i] = Pi ^ Gpfx[i-1].
- cout = Gpfx[WIDTH-1].
- ovf = carry into MSB XOR cout.
- All results are exactly WIDTH bits; no truncation beyond the cout/ovf definitions.

Pipeline:
- Stage s holds the P/G vectors after levels [s*STAGE_LEVELS, min((s+1)*STAGE_LEVELS, L)).
- Original P vector and c0 travel alongside for the final sum XOR.
- Each stage has a valid bit v[s].
- The final stage register drives out_* directly: outputs are registered, with no combinational path from in_* to out_*.

Handshake:
- adv[last] = !v[last] | out_ready; adv[s] = !v[s] | adv[s+1]; in_ready = adv[0].
- Accept when in_valid & in_ready. Result appears on out_* exactly NSTG cycles after acceptance if unstalled.
- A stage holds data while not advancing; no beat is ever dropped or duplicated.
- Order is preserved; throughput is 1 beat/cycle when out_ready=1.
- Capacity is NSTG beats. in_ready=0 only when all stages are valid and out_ready=0.
- in_ready is combinational from out_ready (ready chain) — permitted.
- out_sum/out_cout/out_ovf hold stable while out_valid=1 and out_ready=0.

Reset:
- rst_n=0 at a clock edge clears all v[s]. Data registers are don't-care, but out_sum/out_cout/out_ovf are also cleared to 0.
- After reset: out_valid=0, in_ready=1 (in_ready is high even during reset).
- Reset mid-operation discards all in-flight beats; nothing emerges afterwards.

Boundaries:
- WIDTH not a power of two: levels whose distance >= WIDTH are not generated.
- STAGE_LEVELS >= L gives NSTG = 1 (single registered stage).
- Simultaneous out handshake and in accept on a full pipe: both occur, occupancy is unchanged.

Decomposition:
- Package ks_pkg: function ks_levels(width) returning ceil(log2), function ks_stages(levels, per), and typedefs for per-stage PG bundles if the flow allows.
- Sub-module ks_prefix_level: one combinational prefix row, parameters WIDTH and DIST, mapping (P,G) to (P,G) via the black-cell equation.
- Top instantiates L rows with registers inserted per STAGE_LEVELS.

Test Plan:
1. Reset: hold rst_n=0 for 3 clocks with in_valid=1 -> out_valid=0, in_ready=1; after release, out_valid stays 0 until the first accept.
2. WIDTH=16: 0xFFFF+0x0001, cin=0, sub=0 -> out_sum=0x0000, cout=1, ovf=0, out_valid asserted exactly 2 cycles after accept.
3. WIDTH=16: 0x7FFF+0x0001 -> 0x8000, cout=0, ovf=1. Then sub 0x0005-0x0007 -> 0xFFFE, cout=0, ovf=0; in_cin=1 is ignored.
4. Backpressure: 5 back-to-back beats (i+1)+(i+1), out_ready=0 for 4 cycles -> in_ready drops after 2 accepts; sums 2,4,6,8,10 delivered in order with none lost; out_sum stable while stalled.
5. Reset mid-flight: accept 2 beats, assert rst_n=0 one cycle -> neither beat ever appears on out_valid.
6. WIDTH=8, STAGE_LEVELS=1: 0xAA+0x55, cin=1 -> out_sum=0x00, cout=1, latency 3. Random 10k vectors against the behavioural A+B+cin model for WIDTH in {5, 8, 16, 32}.
